hdd_sector_ctrl: RTL and testbench
==================================

Name: hdd_sector_ctrl

Overview:
Sequences single-block transfers between the ProDOS HDD card's 512-byte sector buffer and the host SD block-device interface.
- Accepts the card's one-cycle read/write request pulses and latches the block number.
- Holds the 6502 in wait while a transfer is in flight, then streams the 512 bytes through the card's buffer port.
- Also owns image-mount state: tracks mounted, write-protect and image size, and range-checks every request.

Parameters:
LBA_BASE, 0, 32-bit offset added to the block number to form sd_lba
TIMEOUT_CYCLES, 4194304, CLK_14M cycles allowed for the transfer before abort (used only with HDD_CTRL_TIMEOUT_EN)

Ports:
CLK_14M  in  1  system clock
RESET_N  in  1  synchronous active-low reset
hdd_read  in  1  one-cycle read request from HDD card
hdd_write  in  1  one-cycle write request from HDD card
sector  in  16  block number from HDD card
img_mounted  in  1  one-cycle pulse: image (re)mounted or ejected
img_readonly  in  1  readonly flag, sampled on img_mounted
img_size  in  64  image size in bytes, sampled on img_mounted
hdd_mounted  out  1  image present (img_size != 0)
hdd_protect  out  1  image write-protected
sd_lba  out  32  block address to host
sd_rd  out  1  host read request
sd_wr  out  1  host write request
sd_ack  in  1  host transfer active
sd_buff_addr  in  9  host byte index
sd_buff_dout  in  8  byte from host
sd_buff_wr  in  1  host byte strobe
sd_buff_din  out  8  byte to host
ram_addr  out  9  sector buffer address
ram_di  out  8  sector buffer write data
ram_we  out  1  sector buffer write enable
ram_do  in  8  sector buffer read data (1-cycle latency)
cpu_wait  out  1  halt 6502 while high
busy  out  1  state != IDLE
err  out  1  sticky error; cleared by next accepted request

Behaviour:
Reset values:
- All outputs 0; state IDLE.
- Mount registers cleared: hdd_mounted=0, hdd_protect=0, blocks=0.

Mount registers:
- On img_mounted: blocks <= img_size[40:9] (32 bits); hdd_mounted <= (img_size != 0); hdd_protect <= img_readonly.
- An img_mounted pulse while busy still updates the registers and also aborts the transfer to ERR.

States:
- IDLE:
  - hdd_read or hdd_write: latch op and sector; err <= 0; cpu_wait <= 1 in the same edge.
  - If the request is not mounted, the block is out of range ({16'h0, sector} >= blocks), or it is a write with protect set: go to ERR. No sd_rd/sd_wr is raised.
  - Otherwise go to REQ.
  - Both request pulses in the same cycle: read wins.
  - Requests arriving while not IDLE are ignored.
- REQ:
  - sd_lba = LBA_BASE + {16'h0, sector}.
  - Raise sd_rd or sd_wr; hold it until sd_ack=1, then drop it and go to XFER.
- XFER:
  - ram_addr = sd_buff_addr.
  - ram_di = sd_buff_dout.
  - ram_we = sd_ack & sd_buff_wr & op_read.
  - sd_buff_din = ram_do.
  - On the sd_ack falling edge, go to DONE.
  - During a write, ram_we stays 0.
- DONE: cpu_wait <= 0; next state IDLE. Exactly one cycle.
- ERR: err <= 1; cpu_wait <= 0; next state IDLE. Exactly one cycle.

Timing:
- Minimum cpu_wait width is 3 cycles: request, REQ with ack already high, then DONE.
- Outside XFER: ram_we=0 and ram_addr=0.
- Reset mid-transfer: everything returns to reset values at once. The host may still finish its ack without effect.

Optional Feature:
HDD_CTRL_TIMEOUT_EN
- Defined: a 22-bit counter clears on leaving IDLE and increments in REQ and XFER. Reaching TIMEOUT_CYCLES-1 forces ERR and drops sd_rd/sd_wr.
- Undefined: no counter; REQ and XFER wait indefinitely.

Decomposition:
Shared package hdd_pkg holds:
- state encoding (IDLE, REQ, XFER, DONE, ERR);
- the ProDOS status constants (0x00, 0x28 NO_DEVICE, 0x2B PROTECT), which the card uses to report err;
- BLOCK_BYTES=512.

Sub-module hdd_mount_regs owns the mount registers and range compare (out_of_range output). The FSM stays in hdd_sector_ctrl.

Test Plan:
1. Mount 0x20000 bytes, pulse hdd_read with sector=5: sd_lba=5 and sd_rd high until ack. The host writes 512 bytes (value = addr[7:0]); ram_we fires 512 times with matching addr/data. cpu_wait falls one cycle after ack falls; err=0.
2. Write sector 0x00FF on a mounted image with protect clear: sd_wr asserted, ram_we stays 0. sd_buff_din equals the buffer byte at sd_buff_addr one cycle later.
3. Mount 0x20000 bytes (256 blocks), read sector=256: no sd_rd, err=1, cpu_wait high for exactly 2 cycles. Sector 255 is then accepted.
4. img_readonly=1, write sector 0: ERR path, err=1, sd_wr never asserted. A following read clears err.
5. hdd_read and hdd_write in the same cycle: read performed. A hdd_read during XFER is ignored; sd_rd is never reasserted.
6. RESET_N low mid-XFER: all outputs 0 next cycle. With HDD_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=64, withholding sd_ack gives err=1 at cycle 64 with sd_rd dropped.

Source files
------------

// File: rtl/hdd_pkg.sv
// hdd_pkg: shared types and constants for the ProDOS HDD sector controller.
// Holds the FSM state encoding, the ProDOS status codes the card reports, and the
// block geometry helper used by the mount registers.
package hdd_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StXfer,
        StDone,
        StErr
    } hdd_state_e;

    // ProDOS status codes the card returns to the 6502 (err selects between them)
    localparam logic [7:0] PRODOS_OK        = 8'h00;
    localparam logic [7:0] PRODOS_NO_DEVICE = 8'h28;
    localparam logic [7:0] PRODOS_PROTECT   = 8'h2B;

    localparam int unsigned BLOCK_BYTES = 512;
    localparam int unsigned BLOCK_SHIFT = $clog2(BLOCK_BYTES);

    // Image size in bytes to whole 512-byte blocks (bits [40:9] of the size)
    function automatic logic [31:0] size_to_blocks(input logic [63:0] size_bytes);
        return 32'(size_bytes >> BLOCK_SHIFT);
    endfunction

endpackage

// File: rtl/hdd_sector_ctrl_if.sv
// hdd_sector_ctrl_if: host SD block-device handshake and byte-stream signals.
// master = sector controller, slave = host block device.
interface hdd_sector_ctrl_if;

    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic        sd_buff_wr;
    logic [7:0]  sd_buff_din;

    modport master (
        output sd_lba, sd_rd, sd_wr, sd_buff_din,
        input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
    );

    modport slave (
        input  sd_lba, sd_rd, sd_wr, sd_buff_din,
        output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
    );

endinterface

// File: rtl/hdd_mount_regs.sv
// hdd_mount_regs: image-mount state (mounted, write-protect, size in blocks)
// captured on each img_mounted pulse, plus the block range compare.
module hdd_mount_regs
    import hdd_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        img_mounted,
    input  logic        img_readonly,
    input  logic [63:0] img_size,
    input  logic [15:0] sector,
    output logic        hdd_mounted,
    output logic        hdd_protect,
    output logic        out_of_range
);

    logic [31:0] blocks;

    // Capture the image description whenever the host (re)mounts or ejects
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blocks      <= '0;
            hdd_mounted <= 1'b0;
            hdd_protect <= 1'b0;
        end else if (img_mounted) begin
            blocks      <= size_to_blocks(img_size);
            hdd_mounted <= (img_size != 64'd0);
            hdd_protect <= img_readonly;
        end
    end

    // A zero-block image rejects every sector, even if some bytes are present
    always_comb begin
        out_of_range = ({16'h0, sector} >= blocks);
    end

endmodule

// File: rtl/hdd_sector_ctrl.sv
// hdd_sector_ctrl: sequences single-block transfers between the HDD card sector
// buffer and the host SD block device, holding the 6502 in wait meanwhile.
// Optional macro HDD_CTRL_TIMEOUT_EN adds an abort after TIMEOUT_CYCLES in REQ/XFER.
module hdd_sector_ctrl
    import hdd_pkg::*;
#(
    parameter logic [31:0] LBA_BASE       = 32'h0,
    parameter int unsigned TIMEOUT_CYCLES = 4194304
) (
    input  logic              CLK_14M,
    input  logic              RESET_N,
    input  logic              hdd_read,
    input  logic              hdd_write,
    input  logic [15:0]       sector,
    input  logic              img_mounted,
    input  logic              img_readonly,
    input  logic [63:0]       img_size,
    output logic              hdd_mounted,
    output logic              hdd_protect,
    hdd_sector_ctrl_if.master sd,
    output logic [8:0]        ram_addr,
    output logic [7:0]        ram_di,
    output logic              ram_we,
    input  logic [7:0]        ram_do,
    output logic              cpu_wait,
    output logic              busy,
    output logic              err
);

    hdd_state_e  state, state_next;
    logic        op_read, op_read_next;
    logic [15:0] sector_q, sector_next;
    logic        err_next, wait_next;
    logic        out_of_range;
    logic        timeout;
    logic        in_req, in_xfer;

    hdd_mount_regs u_mount (
        .clk          (CLK_14M),
        .rst_n        (RESET_N),
        .img_mounted  (img_mounted),
        .img_readonly (img_readonly),
        .img_size     (img_size),
        .sector       (sector),
        .hdd_mounted  (hdd_mounted),
        .hdd_protect  (hdd_protect),
        .out_of_range (out_of_range)
    );

    assign in_req  = (state == StReq);
    assign in_xfer = (state == StXfer);

`ifdef HDD_CTRL_TIMEOUT_EN
    logic [21:0] tmo_cnt;

    // Transfer watchdog: held at zero in IDLE, counts every REQ/XFER cycle
    always_ff @(posedge CLK_14M) begin
        if (!RESET_N || state == StIdle) begin
            tmo_cnt <= '0;
        end else if (in_req || in_xfer) begin
            tmo_cnt <= tmo_cnt + 22'd1;
        end
    end

    assign timeout = (in_req || in_xfer) && (tmo_cnt == 22'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // Control registers: state, latched request and the wait/error flags
    always_ff @(posedge CLK_14M) begin
        if (!RESET_N) begin
            state    <= StIdle;
            op_read  <= 1'b0;
            sector_q <= '0;
            err      <= 1'b0;
            cpu_wait <= 1'b0;
        end else begin
            state    <= state_next;
            op_read  <= op_read_next;
            sector_q <= sector_next;
            err      <= err_next;
            cpu_wait <= wait_next;
        end
    end

    // Next-state logic; request checks use the mount state before any same-cycle remount
    always_comb begin
        state_next   = state;
        op_read_next = op_read;
        sector_next  = sector_q;
        err_next     = err;
        wait_next    = cpu_wait;
        case (state)
            StIdle: begin
                if (hdd_read || hdd_write) begin
                    op_read_next = hdd_read;
                    sector_next  = sector;
                    err_next     = 1'b0;
                    wait_next    = 1'b1;
                    if (!hdd_mounted || out_of_range || (!hdd_read && hdd_protect)) begin
                        state_next = StErr;
                    end else begin
                        state_next = StReq;
                    end
                end
            end
            StReq: begin
                if (sd.sd_ack) begin
                    state_next = StXfer;
                end
            end
            StXfer: begin
                // XFER is only entered with ack high, so ack low here is its falling edge
                if (!sd.sd_ack) begin
                    state_next = StDone;
                end
            end
            StDone: begin
                wait_next  = 1'b0;
                state_next = StIdle;
            end
            StErr: begin
                err_next   = 1'b1;
                wait_next  = 1'b0;
                state_next = StIdle;
            end
            default: begin
                state_next = StIdle;
            end
        endcase
        // Remount/eject or watchdog expiry abandons an in-flight transfer
        if ((img_mounted || timeout) && (state inside {StReq, StXfer, StDone})) begin
            state_next = StErr;
        end
    end

    // Host request and buffer routing, all forced to zero outside their states
    always_comb begin
        busy           = (state != StIdle);
        sd.sd_rd       = in_req && op_read;
        sd.sd_wr       = in_req && !op_read;
        sd.sd_lba      = (in_req || in_xfer) ? (LBA_BASE + {16'h0, sector_q}) : 32'h0;
        sd.sd_buff_din = in_xfer ? ram_do : 8'h0;
        ram_addr       = in_xfer ? sd.sd_buff_addr : 9'h0;
        ram_di         = in_xfer ? sd.sd_buff_dout : 8'h0;
        ram_we         = in_xfer && sd.sd_ack && sd.sd_buff_wr && op_read;
    end

endmodule

// File: tb/tb_hdd_sector_ctrl.sv
// tb_hdd_sector_ctrl: directed and randomized checks of hdd_sector_ctrl against a
// reference model of mount state and sector buffer contents.
module tb_hdd_sector_ctrl;

  localparam logic [31:0] LBA_BASE = 32'h0000_0800;
  localparam int unsigned TMO      = 64;

  logic        CLK_14M;
  logic        RESET_N;
  logic        hdd_read, hdd_write;
  logic [15:0] sector;
  logic        img_mounted, img_readonly;
  logic [63:0] img_size;
  logic        hdd_mounted, hdd_protect;
  logic [8:0]  ram_addr;
  logic [7:0]  ram_di;
  logic        ram_we;
  logic [7:0]  ram_do;
  logic        cpu_wait, busy, err;

  hdd_sector_ctrl_if sd_if ();

  hdd_sector_ctrl #(
    .LBA_BASE       (LBA_BASE),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLK_14M      (CLK_14M),
    .RESET_N      (RESET_N),
    .hdd_read     (hdd_read),
    .hdd_write    (hdd_write),
    .sector       (sector),
    .img_mounted  (img_mounted),
    .img_readonly (img_readonly),
    .img_size     (img_size),
    .hdd_mounted  (hdd_mounted),
    .hdd_protect  (hdd_protect),
    .sd           (sd_if),
    .ram_addr     (ram_addr),
    .ram_di       (ram_di),
    .ram_we       (ram_we),
    .ram_do       (ram_do),
    .cpu_wait     (cpu_wait),
    .busy         (busy),
    .err          (err)
  );

  initial CLK_14M = 1'b0;
  always #5 CLK_14M = ~CLK_14M;

  // Card sector buffer: synchronous RAM with one cycle read latency
  logic [7:0] mem [512];
  always @(posedge CLK_14M) begin
    if (ram_we) mem[ram_addr] <= ram_di;
    ram_do <= mem[ram_addr];
  end

  // Reference model
  int          checks;
  int          failures;
  logic [63:0] m_size;
  logic        m_protect;
  logic [7:0]  exp_buf [512];

  task automatic check(input string tag, input logic ok);
    checks++;
    if (ok !== 1'b1) begin
      failures++;
      $error("FAIL %s", tag);
    end
  endtask

  task automatic step();
    @(posedge CLK_14M);
    #1;
  endtask

  function automatic logic exp_reject(input logic is_read, input logic [15:0] sec);
    return (m_size == 64'd0) || ({48'd0, sec} >= (m_size / 64'd512))
        || (!is_read && m_protect);
  endfunction

  task automatic mount(input logic [63:0] size, input logic ro);
    img_size     = size;
    img_readonly = ro;
    img_mounted  = 1'b1;
    step();
    img_mounted = 1'b0;
    m_size      = size;
    m_protect   = ro;
    check("mount_mounted", hdd_mounted === (size != 64'd0));
    check("mount_protect", hdd_protect === ro);
  endtask

  // One card request; seq walks all addresses in order, otherwise nbytes random ones
  task automatic run_request(input logic is_read, input logic [15:0] sec, input int nbytes,
                             input logic seq, input logic both, input logic poke);
    logic       rej;
    int         w;
    logic [8:0] a;
    logic [7:0] d;
    rej       = exp_reject(is_read, sec);
    hdd_read  = is_read;
    hdd_write = !is_read || both;
    sector    = sec;
    step();
    hdd_read  = 1'b0;
    hdd_write = 1'b0;
    check("req_wait", cpu_wait === 1'b1);
    check("req_err_clear", err === 1'b0);
    if (rej) begin
      check("rej_no_rd", sd_if.sd_rd === 1'b0);
      check("rej_no_wr", sd_if.sd_wr === 1'b0);
      w = 1;  // the request strobe cycle
      while (cpu_wait === 1'b1 && w < 8) begin
        w++;
        step();
      end
      check("rej_wait_cycles", w === 2);
      check("rej_err", err === 1'b1);
      check("rej_idle", busy === 1'b0);
    end else begin
      check("acc_rd", sd_if.sd_rd === is_read);
      check("acc_wr", sd_if.sd_wr === !is_read);
      check("acc_lba", sd_if.sd_lba === (LBA_BASE + {16'h0, sec}));
      repeat ($urandom_range(0, 3)) begin
        step();
        check("acc_hold", {sd_if.sd_rd, sd_if.sd_wr} === {is_read, !is_read});
      end
      sd_if.sd_ack = 1'b1;
      step();
      check("xfer_req_drop", {sd_if.sd_rd, sd_if.sd_wr} === 2'b00);
      check("xfer_busy", busy === 1'b1);
      for (int i = 0; i < nbytes; i++) begin
        a = seq ? 9'(i) : 9'($urandom_range(0, 511));
        d = seq ? 8'(i) : 8'($urandom);
        sd_if.sd_buff_addr = a;
        sd_if.sd_buff_dout = d;
        sd_if.sd_buff_wr   = is_read ? 1'b1 : 1'($urandom);
        if (poke && i == 0) begin
          hdd_read  = 1'b1;
          hdd_write = 1'b1;
        end
        #1;
        if (is_read) begin
          check("rd_we", ram_we === 1'b1);
          check("rd_addr", ram_addr === a);
          check("rd_data", ram_di === d);
          exp_buf[a] = d;
        end else begin
          check("wr_no_we", ram_we === 1'b0);
        end
        step();
        hdd_read  = 1'b0;
        hdd_write = 1'b0;
        check("xfer_no_req", {sd_if.sd_rd, sd_if.sd_wr} === 2'b00);
        if (!is_read) check("wr_din", sd_if.sd_buff_din === exp_buf[a]);
      end
      sd_if.sd_buff_wr = 1'b0;
      sd_if.sd_ack     = 1'b0;
      step();
      check("done_wait", cpu_wait === 1'b1);
      check("done_busy", busy === 1'b1);
      step();
      check("end_wait", cpu_wait === 1'b0);
      check("end_busy", busy === 1'b0);
      check("end_err", err === 1'b0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] sec;
    logic [31:0] blks;
    checks             = 0;
    failures           = 0;
    m_size             = '0;
    m_protect          = 1'b0;
    RESET_N            = 1'b0;
    hdd_read           = 1'b0;
    hdd_write          = 1'b0;
    sector             = '0;
    img_mounted        = 1'b0;
    img_readonly       = 1'b0;
    img_size           = '0;
    sd_if.sd_ack       = 1'b0;
    sd_if.sd_buff_addr = '0;
    sd_if.sd_buff_dout = '0;
    sd_if.sd_buff_wr   = 1'b0;
    for (int i = 0; i < 512; i++) exp_buf[i] = 8'h00;
    step();
    step();
    check("rst_outputs", {cpu_wait, busy, err, hdd_mounted, hdd_protect, ram_we,
                          sd_if.sd_rd, sd_if.sd_wr} === 8'h00);
    check("rst_lba", sd_if.sd_lba === 32'h0);
    RESET_N = 1'b1;
    step();

    // Unmounted image rejects
    run_request(1'b1, 16'd0, 0, 1'b0, 1'b0, 1'b0);

    // Full sequential read of sector 5, then full write-back of sector 0xFF
    mount(64'h2_0000, 1'b0);
    run_request(1'b1, 16'd5, 512, 1'b1, 1'b0, 1'b0);
    run_request(1'b0, 16'h00FF, 512, 1'b1, 1'b0, 1'b0);

    // 256-block boundary
    run_request(1'b1, 16'd256, 0, 1'b0, 1'b0, 1'b0);
    run_request(1'b1, 16'd255, 16, 1'b0, 1'b0, 1'b0);

    // Write-protect, then a read clears err
    mount(64'h2_0000, 1'b1);
    run_request(1'b0, 16'd0, 0, 1'b0, 1'b0, 1'b0);
    run_request(1'b1, 16'd0, 8, 1'b0, 1'b0, 1'b0);

    // Simultaneous strobes read; strobes during XFER ignored
    mount(64'h2_0000, 1'b0);
    run_request(1'b1, 16'd7, 8, 1'b0, 1'b1, 1'b1);

    // Remount while a request is pending aborts to ERR
    hdd_read = 1'b1;
    sector   = 16'd3;
    step();
    hdd_read = 1'b0;
    check("abort_pre_rd", sd_if.sd_rd === 1'b1);
    img_size     = 64'h400;
    img_readonly = 1'b1;
    img_mounted  = 1'b1;
    step();
    img_mounted = 1'b0;
    m_size      = 64'h400;
    m_protect   = 1'b1;
    check("abort_rd_drop", sd_if.sd_rd === 1'b0);
    check("abort_busy", busy === 1'b1);
    check("abort_protect", hdd_protect === 1'b1);
    step();
    check("abort_err", err === 1'b1);
    check("abort_wait", cpu_wait === 1'b0);

    // Randomized mounts and requests, biased toward the last valid block
    for (int n = 0; n < 24; n++) begin
      if (n % 3 == 0) begin
        blks = 32'($urandom_range(0, 300));
        mount(64'(blks) * 64'd512 + 64'($urandom_range(0, 511)), 1'($urandom));
      end
      blks = 32'(m_size / 64'd512);
      case ($urandom_range(0, 2))
        0: sec = (blks == 0) ? 16'd0 : 16'(blks - 1);
        1: sec = 16'(blks);
        default: sec = 16'($urandom_range(0, 320));
      endcase
      run_request(1'($urandom), sec, 6, 1'b0, 1'b0, 1'b0);
    end

    // Reset in the middle of a read transfer
    mount(64'h2_0000, 1'b0);
    hdd_read = 1'b1;
    sector   = 16'd9;
    step();
    hdd_read     = 1'b0;
    sd_if.sd_ack = 1'b1;
    step();
    sd_if.sd_buff_addr = 9'h1A5;
    sd_if.sd_buff_dout = 8'h5A;
    sd_if.sd_buff_wr   = 1'b1;
    step();
    RESET_N = 1'b0;
    step();
    m_size    = '0;
    m_protect = 1'b0;
    check("rst_mid_flags", {cpu_wait, busy, err, hdd_mounted, hdd_protect, ram_we,
                            sd_if.sd_rd, sd_if.sd_wr} === 8'h00);
    check("rst_mid_addr", ram_addr === 9'h0);
    check("rst_mid_di", ram_di === 8'h0);
    check("rst_mid_din", sd_if.sd_buff_din === 8'h0);
    check("rst_mid_lba", sd_if.sd_lba === 32'h0);
    RESET_N = 1'b1;
    step();
    sd_if.sd_buff_wr = 1'b0;
    sd_if.sd_ack     = 1'b0;
    step();
    check("rst_after_idle", busy === 1'b0);
    run_request(1'b1, 16'd0, 0, 1'b0, 1'b0, 1'b0);

`ifdef HDD_CTRL_TIMEOUT_EN
    // Withheld ack: REQ lasts TMO cycles, then ERR
    mount(64'h2_0000, 1'b0);
    hdd_read = 1'b1;
    sector   = 16'd1;
    step();
    hdd_read = 1'b0;
    repeat (TMO - 1) step();
    check("tmo_rd_last", sd_if.sd_rd === 1'b1);
    step();
    check("tmo_rd_drop", sd_if.sd_rd === 1'b0);
    check("tmo_busy", busy === 1'b1);
    step();
    check("tmo_err", err === 1'b1);
    check("tmo_wait", cpu_wait === 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
